// File: rtl/ether_tx_pkg.sv
// Shared types, frame constants and CRC-32 helpers for the RMII Ethernet transmitter.
// Header bytes are stored MSB-first so index 0 is the first byte on the wire.
package ether_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    PAD,
    FCS,
    IPG
  } state_t;

  localparam logic [47:0]  DEST_MAC      = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0]  SRC_MAC       = 48'h00_00_00_00_00_01;
  localparam logic [15:0]  ETHERTYPE     = 16'h88B5;
  localparam int           MAX_PAYLOAD   = 1500;
  localparam int           MIN_PAYLOAD   = 46;
  localparam int           IPG_CYCLES    = 48;
  localparam logic [7:0]   PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]   SFD_BYTE      = 8'hD5;
  localparam logic [31:0]  CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0]  CRC_POLY      = 32'hEDB8_8320;
  localparam int           CNT_W         = $clog2(MAX_PAYLOAD + 1);
  localparam logic [111:0] HEADER_BITS   = {DEST_MAC, SRC_MAC, ETHERTYPE};

  function automatic logic [7:0] header_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (idx == 4'(i)) b = HEADER_BITS[8*(13-i) +: 8];
    end
    return b;
  endfunction

  // Two reflected CRC steps, dibit bit 0 enters first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Running Ethernet CRC-32 register advanced by one RMII dibit per enabled cycle.
// The output is the raw register; the frame check sequence is its complement.
module crc32_dibit
  import ether_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_step(crc, dibit);
    end
  end

endmodule

// File: rtl/ether_tx.sv
// RMII Ethernet frame transmitter: preamble, fixed header, streamed payload, pad, FCS, IPG.
// Valid/ready: a payload byte moves on a rising edge where axiiv && axiir are both high.
module ether_tx
  import ether_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(13);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYCLES - 1);

  state_t           state, state_n;
  logic [1:0]       di, di_n;
  logic [CNT_W-1:0] byte_cnt, cnt_n;
  logic [7:0]       pay_byte, pay_n;
  logic             last_flag, last_n;
  logic             drain, drain_n;
  logic             done_n, err_n;
  logic             short_frame;
  logic [7:0]       cur_byte;
  logic [31:0]      crc;
  logic [31:0]      fcs_word;
  logic             crc_clear, crc_en;

  assign short_frame = (byte_cnt < MIN_CNT);
  assign fcs_word    = ~crc;
  assign axiov       = (state == PREAMBLE) || (state == HEADER) || (state == PAYLOAD) ||
                       (state == PAD) || (state == FCS);
  assign crc_clear   = (state == IDLE) || (state == PREAMBLE);
  assign crc_en      = (state == HEADER) || (state == PAYLOAD) || (state == PAD);

  crc32_dibit u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .dibit (axiod),
    .crc   (crc)
  );

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      PREAMBLE: cur_byte = (byte_cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
      HEADER:   cur_byte = header_byte(byte_cnt[3:0]);
      PAYLOAD:  cur_byte = pay_byte;
      FCS:      cur_byte = fcs_word[{byte_cnt[1:0], 3'b000} +: 8];
      default:  cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    axiod = 2'b00;
    if (axiov) axiod = cur_byte[{di, 1'b0} +: 2];
  end

  // The next payload byte is requested on the last dibit of the current byte so the
  // wire never idles between bytes.
  always_comb begin
    state_n = state;
    di_n    = di + 2'd1;
    cnt_n   = byte_cnt;
    pay_n   = pay_byte;
    last_n  = last_flag;
    drain_n = drain;
    done_n  = 1'b0;
    err_n   = 1'b0;
    axiir   = 1'b0;
    case (state)
      IDLE: begin
        di_n  = 2'd0;
        cnt_n = '0;
        if (axiiv && !drain) state_n = PREAMBLE;
      end
      PREAMBLE: if (di == 2'd3) begin
        if (byte_cnt == PRE_LAST) begin
          state_n = HEADER;
          cnt_n   = '0;
        end else begin
          cnt_n = byte_cnt + 1'b1;
        end
      end
      HEADER: if (di == 2'd3) begin
        if (byte_cnt == HDR_LAST) begin
          axiir = 1'b1;
          if (axiiv) begin
            state_n = PAYLOAD;
            pay_n   = axiid;
            last_n  = axiil;
            cnt_n   = CNT_W'(1);
          end else begin
            state_n = PAD;
            err_n   = 1'b1;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = byte_cnt + 1'b1;
        end
      end
      PAYLOAD: if (di == 2'd3) begin
        if (last_flag) begin
          state_n = short_frame ? PAD : FCS;
          if (!short_frame) cnt_n = '0;
        end else if (byte_cnt == MAX_CNT) begin
          state_n = FCS;
          cnt_n   = '0;
          err_n   = 1'b1;
          drain_n = 1'b1;
        end else begin
          axiir = 1'b1;
          if (axiiv) begin
            pay_n  = axiid;
            last_n = axiil;
            cnt_n  = byte_cnt + 1'b1;
          end else begin
            err_n   = 1'b1;
            state_n = short_frame ? PAD : FCS;
            if (!short_frame) cnt_n = '0;
          end
        end
      end
      PAD: if (di == 2'd3) begin
        if (byte_cnt == MIN_CNT - 1'b1) begin
          state_n = FCS;
          cnt_n   = '0;
        end else begin
          cnt_n = byte_cnt + 1'b1;
        end
      end
      FCS: if (di == 2'd3) begin
        if (byte_cnt == FCS_LAST) begin
          state_n = IPG;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = byte_cnt + 1'b1;
        end
      end
      IPG: begin
        di_n = 2'd0;
        if (byte_cnt == IPG_LAST) begin
          cnt_n   = '0;
          state_n = (axiiv && !drain) ? PREAMBLE : IDLE;
        end else begin
          cnt_n = byte_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Oversize drain: swallow the rest of the source frame while FCS/IPG proceed.
    if (drain) begin
      axiir = 1'b1;
      if (axiiv && axiil) drain_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      di        <= 2'd0;
      byte_cnt  <= '0;
      pay_byte  <= 8'h00;
      last_flag <= 1'b0;
      drain     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      di        <= di_n;
      byte_cnt  <= cnt_n;
      pay_byte  <= pay_n;
      last_flag <= last_n;
      drain     <= drain_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_ether_tx.sv
// Bench for ether_tx: randomized payloads checked against a byte-level Ethernet frame model.
module tb_ether_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [7:0] axiid = 8'h00;
  logic       axiil = 1'b0;
  logic       axiir, axiov, done, err;
  logic [1:0] axiod;

  logic        c_clear = 1'b0;
  logic        c_en = 1'b0;
  logic [1:0]  c_dibit = 2'b00;
  logic [31:0] c_crc;

  int n_tests = 0;
  int n_fail  = 0;

  ether_tx dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiil (axiil),
    .axiir (axiir),
    .axiov (axiov),
    .axiod (axiod),
    .done  (done),
    .err   (err)
  );

  crc32_dibit crc_u (
    .clk   (clk),
    .rst   (rst),
    .clear (c_clear),
    .en    (c_en),
    .dibit (c_dibit),
    .crc   (c_crc)
  );

  always #10 clk = ~clk;

  // source model and expected stream
  logic [7:0] src_data[$];
  logic       src_last[$];
  int         src_idx  = 0;
  int         drop_idx = -1;
  logic [1:0] exp_q[$];

  // monitor
  logic [1:0] rx_q[$];
  int         gap_q[$];
  int         ov_cycles = 0;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         idle_bad  = 0;
  int         low_run   = 0;
  logic       had_frame = 1'b0;
  logic       prev_ov   = 1'b0;
  logic       mon_rst   = 1'b0;

  always @(negedge clk) begin
    if (mon_rst) begin
      rx_q.delete();
      gap_q.delete();
      ov_cycles <= 0;
      done_cnt  <= 0;
      err_cnt   <= 0;
      idle_bad  <= 0;
      low_run   <= 0;
      had_frame <= 1'b0;
      prev_ov   <= 1'b0;
    end else begin
      if (axiov === 1'b1) begin
        rx_q.push_back(axiod);
        ov_cycles <= ov_cycles + 1;
        if (!prev_ov && had_frame) gap_q.push_back(low_run);
        had_frame <= 1'b1;
        low_run   <= 0;
      end else begin
        low_run <= low_run + 1;
        if (axiod !== 2'b00) idle_bad <= idle_bad + 1;
      end
      prev_ov <= axiov;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (err === 1'b1) err_cnt <= err_cnt + 1;
    end
  end

  // Reference frame: preamble, SFD, header, payload padded to 46, byte-wise CRC-32 LSB first.
  task automatic model_frame(input logic [7:0] pay[$]);
    logic [7:0]   body[$];
    logic [7:0]   all_b[$];
    logic [111:0] hdr;
    logic [31:0]  c;
    logic [7:0]   b;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 16'h88B5};
    body = {};
    for (int i = 0; i < 14; i++) body.push_back(hdr[8*(13-i) +: 8]);
    foreach (pay[i]) body.push_back(pay[i]);
    while (body.size() < 14 + 46) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      c = c ^ {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    all_b = {};
    for (int i = 0; i < 7; i++) all_b.push_back(8'h55);
    all_b.push_back(8'hD5);
    foreach (body[i]) all_b.push_back(body[i]);
    for (int i = 0; i < 4; i++) all_b.push_back(c[8*i +: 8]);
    foreach (all_b[i]) begin
      b = all_b[i];
      for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
    end
  endtask

  function automatic int frame_diffs();
    int d;
    d = 0;
    if (rx_q.size() != exp_q.size()) d++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) d++;
    end
    return d;
  endfunction

  function automatic int frame_cycles(input int n);
    return 4 * (8 + 14 + ((n < 46) ? 46 : n) + 4);
  endfunction

  task automatic rand_pay(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic add_frame(input logic [7:0] pay[$]);
    foreach (pay[i]) begin
      src_data.push_back(pay[i]);
      src_last.push_back(i == pay.size() - 1);
    end
  endtask

  task automatic clear_all();
    axiiv = 1'b0;
    axiid = 8'h00;
    axiil = 1'b0;
    src_data.delete();
    src_last.delete();
    src_idx  = 0;
    drop_idx = -1;
    exp_q.delete();
    mon_rst = 1'b1;
    @(negedge clk);
    #1;
    mon_rst = 1'b0;
  endtask

  // Per-cycle source driver; stops 52 cycles after n_done frames or at the cycle budget.
  task automatic drive(input int n_done, input int budget, input int rst_at, output logic ov_after);
    int   cyc;
    int   tail;
    logic fin;
    logic timed_out;
    cyc = 0;
    tail = -1;
    fin = 1'b0;
    timed_out = 1'b0;
    ov_after = 1'b1;
    while (!fin) begin
      @(negedge clk);
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        ov_after = axiov;
        rst = 1'b1;
        axiiv = 1'b0;
        axiid = 8'h00;
        axiil = 1'b0;
        fin = 1'b1;
      end else begin
        if (cyc == rst_at) rst = 1'b0;
        if (src_idx < src_data.size() && src_idx != drop_idx) begin
          axiiv = 1'b1;
          axiid = src_data[src_idx];
          axiil = src_last[src_idx];
        end else begin
          axiiv = 1'b0;
          axiid = 8'h00;
          axiil = 1'b0;
        end
        #1;
        if (rst && axiiv && axiir === 1'b1) src_idx++;
        if (tail < 0 && done_cnt >= n_done) tail = 0;
        if (tail >= 0) begin
          tail++;
          if (tail > 52) fin = 1'b1;
        end
        cyc++;
        if (cyc > budget) begin
          timed_out = 1'b1;
          fin = 1'b1;
        end
      end
    end
    n_tests++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL drive_timeout: got %0d done pulses after %0d cycles, want %0d", done_cnt, budget, n_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    axiiv = 1'b1;
    axiid = 8'hAA;
    repeat (3) @(negedge clk);
    n_tests++; if (axiov !== 1'b0) begin n_fail++; $display("FAIL reset_axiov: got %b want 0", axiov); end
    n_tests++; if (axiod !== 2'b00) begin n_fail++; $display("FAIL reset_axiod: got %b want 00", axiod); end
    n_tests++; if (axiir !== 1'b0) begin n_fail++; $display("FAIL reset_axiir: got %b want 0", axiir); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    axiiv = 1'b0;
    axiid = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    clear_all();
  endtask

  task automatic test_crc_vector();
    string      s;
    logic [7:0] b;
    s = "123456789";
    c_clear = 1'b1;
    @(negedge clk);
    c_clear = 1'b0;
    c_en = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      for (int k = 0; k < 4; k++) begin
        c_dibit = b[2*k +: 2];
        @(negedge clk);
      end
    end
    c_en = 1'b0;
    n_tests++;
    if (~c_crc !== 32'hCBF4_3926) begin
      n_fail++;
      $display("FAIL crc_check_vector: got %h want cbf43926", ~c_crc);
    end
  endtask

  task automatic test_min_frame();
    logic [7:0] pay[$];
    logic       ov;
    logic [1:0] want;
    int         bad;
    clear_all();
    pay = {};
    for (int i = 0; i < 46; i++) pay.push_back(8'(i));
    add_frame(pay);
    model_frame(pay);
    drive(1, 1000, -1, ov);
    bad = frame_diffs();
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL min_dibits: got %0d bad dibits (rx %0d exp %0d) want 0", bad, rx_q.size(), exp_q.size()); end
    n_tests++; if (ov_cycles !== 288) begin n_fail++; $display("FAIL min_len: got %0d want 288", ov_cycles); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      want = (i == 31) ? 2'b11 : 2'b01;
      if (i >= rx_q.size() || rx_q[i] !== want) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL min_preamble: got %0d bad preamble dibits want 0", bad); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL min_done: got %0d want 1", done_cnt); end
    n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL min_err: got %0d want 0", err_cnt); end
    n_tests++; if (src_idx !== 46) begin n_fail++; $display("FAIL min_consumed: got %0d want 46", src_idx); end
    n_tests++; if (idle_bad !== 0) begin n_fail++; $display("FAIL min_idle_axiod: got %0d nonzero idle dibits want 0", idle_bad); end
  endtask

  task automatic test_single_byte();
    logic [7:0] pay[$];
    logic       ov;
    int         bad;
    clear_all();
    pay = {8'hA5};
    add_frame(pay);
    model_frame(pay);
    drive(1, 1000, -1, ov);
    bad = frame_diffs();
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL single_dibits: got %0d bad dibits want 0", bad); end
    n_tests++; if (ov_cycles !== 288) begin n_fail++; $display("FAIL single_len: got %0d want 288", ov_cycles); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL single_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_underrun();
    logic [7:0] pay[$];
    logic [7:0] sent[$];
    logic       ov;
    int         bad;
    clear_all();
    rand_pay(20, pay);
    add_frame(pay);
    drop_idx = 10;
    sent = {};
    for (int i = 0; i < 10; i++) sent.push_back(pay[i]);
    model_frame(sent);
    drive(1, 1000, -1, ov);
    bad = frame_diffs();
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL underrun_dibits: got %0d bad dibits want 0", bad); end
    n_tests++; if (ov_cycles !== 288) begin n_fail++; $display("FAIL underrun_len: got %0d want 288", ov_cycles); end
    n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL underrun_err: got %0d want 1", err_cnt); end
    n_tests++; if (src_idx !== 10) begin n_fail++; $display("FAIL underrun_consumed: got %0d want 10", src_idx); end
  endtask

  task automatic test_random_frames();
    logic [7:0] pay[$];
    logic       ov;
    int         bad;
    int         lens[4];
    lens = '{45, 47, 0, 0};
    lens[2] = $urandom_range(1, 120);
    lens[3] = $urandom_range(1, 120);
    for (int f = 0; f < 4; f++) begin
      clear_all();
      rand_pay(lens[f], pay);
      add_frame(pay);
      model_frame(pay);
      drive(1, 1500, -1, ov);
      bad = frame_diffs();
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rand_dibits len %0d: got %0d bad dibits want 0", lens[f], bad); end
      n_tests++; if (ov_cycles !== frame_cycles(lens[f])) begin n_fail++; $display("FAIL rand_len len %0d: got %0d want %0d", lens[f], ov_cycles, frame_cycles(lens[f])); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    logic       ov;
    int         bad;
    int         g;
    clear_all();
    rand_pay(60, p1);
    rand_pay(60, p2);
    add_frame(p1);
    add_frame(p2);
    model_frame(p1);
    model_frame(p2);
    drive(2, 2000, -1, ov);
    bad = frame_diffs();
    g = (gap_q.size() == 1) ? gap_q[0] : -1;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_dibits: got %0d bad dibits want 0", bad); end
    n_tests++; if (g !== 48) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles (%0d gaps) want 48", g, gap_q.size()); end
    n_tests++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pay[$];
    logic       ov;
    int         bad;
    clear_all();
    rand_pay(1500, pay);
    add_frame(pay);
    drive(1, 500, 100, ov);
    n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_axiov: got %b want 0", ov); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d want 0", done_cnt); end
    clear_all();
    rand_pay(46, pay);
    add_frame(pay);
    model_frame(pay);
    drive(1, 1000, -1, ov);
    bad = frame_diffs();
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_next_dibits: got %0d bad dibits want 0", bad); end
    n_tests++; if (ov_cycles !== 288) begin n_fail++; $display("FAIL rstmid_next_len: got %0d want 288", ov_cycles); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rstmid_next_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_oversize();
    logic [7:0] pay[$];
    logic [7:0] sent[$];
    logic       ov;
    int         bad;
    clear_all();
    rand_pay(1502, pay);
    add_frame(pay);
    sent = {};
    for (int i = 0; i < 1500; i++) sent.push_back(pay[i]);
    model_frame(sent);
    drive(1, 8000, -1, ov);
    bad = frame_diffs();
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL over_dibits: got %0d bad dibits want 0", bad); end
    n_tests++; if (ov_cycles !== frame_cycles(1500)) begin n_fail++; $display("FAIL over_len: got %0d want %0d", ov_cycles, frame_cycles(1500)); end
    n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL over_err: got %0d want 1", err_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL over_done: got %0d want 1", done_cnt); end
    n_tests++; if (src_idx !== 1502) begin n_fail++; $display("FAIL over_drained: got %0d want 1502", src_idx); end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_min_frame();
    test_single_byte();
    test_underrun();
    test_random_frames();
    test_back_to_back();
    test_reset_mid();
    test_oversize();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
